// File: rtl/merge_memory_banked.sv
// Banked SRAM read merger: maps a flat word address onto NUM_BANKS macros, aligns a bank tag with the macro
// latency and queues steered read data in a show-ahead response FIFO. MERGE_MEMORY_RSP_ADDR_EN adds rsp_addr.
module merge_memory_banked #(
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned BANK_AW    = 9,
    parameter int unsigned DW         = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [BANK_AW+$clog2(NUM_BANKS)-1:0]  req_addr,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [DW-1:0]                         rsp_data,
`ifdef MERGE_MEMORY_RSP_ADDR_EN
    output logic [BANK_AW+$clog2(NUM_BANKS)-1:0]  rsp_addr,
`endif
    output logic [NUM_BANKS-1:0]                  csb_mem,
    output logic [NUM_BANKS*BANK_AW-1:0]          addr_mem,
    input  logic [NUM_BANKS*DW-1:0]               dout_mem
);
    localparam int unsigned SEL_W      = $clog2(NUM_BANKS);
    localparam int unsigned AW         = BANK_AW + SEL_W;
    localparam int unsigned FIFO_DEPTH = RD_LATENCY + 2;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OUT_W      = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
    localparam int unsigned LAST       = RD_LATENCY - 1;

    logic                  accept;
    logic [SEL_W-1:0]      req_bank;
    logic [BANK_AW-1:0]    req_word;

    logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [SEL_W-1:0]      tag_bank_q [RD_LATENCY];
    logic [SEL_W-1:0]      tag_bank_d [RD_LATENCY];

    logic [DW-1:0]         fifo_data_q [FIFO_DEPTH];
    logic [DW-1:0]         fifo_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  req_ready_q, req_ready_d;

    logic                  push;
    logic                  pop;
    logic [DW-1:0]         push_data;
    logic [OUT_W-1:0]      outstanding_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign req_bank = req_addr[AW-1:BANK_AW];
    assign req_word = req_addr[BANK_AW-1:0];
    assign accept   = req_valid && req_ready_q;
    assign push     = tag_vld_q[LAST];
    assign pop      = rsp_valid_q && rsp_ready;

    // Only the addressed macro is selected, and only in the accept cycle
    always_comb begin
        csb_mem  = '1;
        addr_mem = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (accept && (req_bank == SEL_W'(b))) begin
                csb_mem[b]                     = 1'b0;
                addr_mem[b*BANK_AW +: BANK_AW] = req_word;
            end
        end
    end

    always_comb begin
        tag_vld_d     = '0;
        tag_vld_d[0]  = accept;
        tag_bank_d[0] = req_bank;
        for (int unsigned s = 1; s < RD_LATENCY; s++) begin
            tag_vld_d[s]  = tag_vld_q[s-1];
            tag_bank_d[s] = tag_bank_q[s-1];
        end
    end

    // The last tag stage lines up with the macro dout of the bank it names
    always_comb begin
        push_data = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (tag_bank_q[LAST] == SEL_W'(b)) begin
                push_data = dout_mem[b*DW +: DW];
            end
        end
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            fifo_data_d[wr_ptr_q] = push_data;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        rsp_valid_d = (count_d != '0);
    end

    // Credit: everything in flight or queued must fit in the FIFO
    always_comb begin
        outstanding_d = OUT_W'(count_d);
        for (int unsigned s = 0; s < RD_LATENCY; s++) begin
            outstanding_d = outstanding_d + OUT_W'(tag_vld_d[s]);
        end
        req_ready_d = (outstanding_d < OUT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
            for (int unsigned s = 0; s < RD_LATENCY; s++) begin
                tag_bank_q[s] <= '0;
            end
            for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
                fifo_data_q[e] <= '0;
            end
        end else begin
            tag_vld_q   <= tag_vld_d;
            tag_bank_q  <= tag_bank_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = fifo_data_q[rd_ptr_q];

`ifdef MERGE_MEMORY_RSP_ADDR_EN
    logic [AW-1:0] tag_addr_q  [RD_LATENCY];
    logic [AW-1:0] tag_addr_d  [RD_LATENCY];
    logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [AW-1:0] fifo_addr_d [FIFO_DEPTH];

    // Request address travels beside the bank tag and lands in the same FIFO slot as its data
    always_comb begin
        tag_addr_d[0] = req_addr;
        for (int unsigned s = 1; s < RD_LATENCY; s++) begin
            tag_addr_d[s] = tag_addr_q[s-1];
        end
        fifo_addr_d = fifo_addr_q;
        if (push) begin
            fifo_addr_d[wr_ptr_q] = tag_addr_q[LAST];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < RD_LATENCY; s++) begin
                tag_addr_q[s] <= '0;
            end
            for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
                fifo_addr_q[e] <= '0;
            end
        end else begin
            tag_addr_q  <= tag_addr_d;
            fifo_addr_q <= fifo_addr_d;
        end
    end

    assign rsp_addr = fifo_addr_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_merge_memory_banked.sv
// Testbench for merge_memory_banked: behavioural SRAM macros, a request-level reference model (queue of accepted
// reads with their due cycle), table-driven single reads and hand-written streaming/backpressure/reset sequences.
module tb_merge_memory_banked;
`ifdef MERGE_MEMORY_RSP_ADDR_EN
    localparam int unsigned NB  = 8;
    localparam int unsigned LAT = 3;
`else
    localparam int unsigned NB  = 4;
    localparam int unsigned LAT = 1;
`endif
    localparam int unsigned BAW   = 9;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = $clog2(NB);
    localparam int unsigned AW    = BAW + SW;
    localparam int unsigned DEPTH = LAT + 2;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              req_valid = 1'b0;
    logic              rsp_ready = 1'b0;
    logic [AW-1:0]     req_addr  = '0;
    logic              req_ready;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [NB-1:0]     csb_mem;
    logic [NB*BAW-1:0] addr_mem;
    logic [NB*DW-1:0]  dout_mem;
`ifdef MERGE_MEMORY_RSP_ADDR_EN
    logic [AW-1:0]     rsp_addr;
`endif

    always #5 clk = ~clk;

    merge_memory_banked #(
        .NUM_BANKS (NB),
        .BANK_AW   (BAW),
        .DW        (DW),
        .RD_LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
`ifdef MERGE_MEMORY_RSP_ADDR_EN
        .rsp_addr (rsp_addr),
`endif
        .csb_mem  (csb_mem),
        .addr_mem (addr_mem),
        .dout_mem (dout_mem)
    );

    function automatic logic [DW-1:0] mem_word(input int unsigned b, input int unsigned w);
        logic [31:0] v;
        v = (b << 24) ^ (w * 32'h0001_9e37) ^ 32'h5a5a_0000;
        return DW'(v);
    endfunction

    // Behavioural macros: dout appears LAT cycles after a selected edge
    logic [DW-1:0] mac_q [NB][LAT];
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            for (int s = LAT - 1; s > 0; s--) mac_q[b][s] <= mac_q[b][s-1];
            if (!csb_mem[b]) mac_q[b][0] <= mem_word(b, addr_mem[b*BAW +: BAW]);
        end
    end
    always_comb begin
        for (int b = 0; b < NB; b++) dout_mem[b*DW +: DW] = mac_q[b][LAT-1];
    end

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        int unsigned   due;
    } exp_t;
    exp_t        q[$];
    int unsigned cyc      = 0;
    bit          ready_en = 1'b0;
    int          n_cmp    = 0;
    int          n_err    = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: compare at negedge against the model, advance the model at posedge, return 1 time unit later
    task automatic cycle();
        logic          acc, pop, exp_rdy, exp_vld;
        logic [NB-1:0] exp_csb;
        logic [NB*BAW-1:0] exp_am;
        int unsigned   bk;
        exp_t          e;
        @(negedge clk);
        exp_rdy = rst_n && ready_en && (q.size() < DEPTH);
        exp_vld = 1'b0;
        if (q.size() != 0) exp_vld = (q[0].due <= cyc);
        acc = req_valid && exp_rdy;
        pop = exp_vld && rsp_ready;
        bk  = int'(req_addr >> BAW);
        exp_csb = '1;
        exp_am  = '0;
        if (acc) begin
            exp_csb[bk] = 1'b0;
            exp_am[bk*BAW +: BAW] = req_addr[BAW-1:0];
        end
        chk("req_ready", req_ready, exp_rdy);
        chk("rsp_valid", rsp_valid, exp_vld);
        if (exp_vld) begin
            chk("rsp_data", rsp_data, q[0].data);
`ifdef MERGE_MEMORY_RSP_ADDR_EN
            chk("rsp_addr", rsp_addr, q[0].addr);
`endif
        end else if (!rst_n) begin
            chk("rsp_data_rst", rsp_data, 0);
        end
        chk("csb_mem", csb_mem, exp_csb);
        chk("addr_mem", addr_mem, exp_am);
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            ready_en = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.data = mem_word(bk, req_addr[BAW-1:0]);
                e.addr = req_addr;
                e.due  = cyc + LAT + 1;
                q.push_back(e);
            end
            ready_en = 1'b1;
        end
        cyc++;
        #1;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 100 && q.size() != 0; k++) cycle();
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        cycle();
    endtask

    typedef struct {
        logic [AW-1:0]  addr;
        int unsigned    bank;
        logic [BAW-1:0] word;
    } vec_t;
    vec_t vecs[8];

    initial begin
        int unsigned   lat, drops, bubbles, n_acc, n_late;
        bit            seen;
        logic [NB-1:0] vcsb;

        vecs[0] = '{AW'(12'h5A3), 2, 9'h1A3};
        vecs[1] = '{AW'(12'h000), 0, 9'h000};
        vecs[2] = '{AW'(12'h1FF), 0, 9'h1FF};
        vecs[3] = '{AW'(12'h200), 1, 9'h000};
        vecs[4] = '{AW'(12'h7FF), 3, 9'h1FF};
        vecs[5] = '{AW'(12'h400), 2, 9'h000};
        vecs[6] = '{AW'(12'h6C5), 3, 9'h0C5};
        vecs[7] = '{AW'(12'h3A1), 1, 9'h1A1};

        // Reset held, then released between edges
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();
        cycle();

        // Table of single reads
        foreach (vecs[i]) begin
            req_valid = 1'b1;
            req_addr  = vecs[i].addr;
            rsp_ready = 1'b1;
            #1;
            vcsb = '1;
            vcsb[vecs[i].bank] = 1'b0;
            chk("vec_csb", csb_mem, vcsb);
            chk("vec_addr", addr_mem[vecs[i].bank*BAW +: BAW], vecs[i].word);
            cycle();
            req_valid = 1'b0;
            lat = 1;
            while (!rsp_valid && lat < 12) begin
                cycle();
                lat++;
            end
            chk("vec_latency", lat, LAT + 1);
            chk("vec_data", rsp_data, mem_word(vecs[i].bank, vecs[i].word));
`ifdef MERGE_MEMORY_RSP_ADDR_EN
            chk("vec_rsp_addr", rsp_addr, vecs[i].addr);
`endif
            cycle();
        end

        // Back-to-back stream cycling the banks
        drops = 0; bubbles = 0; seen = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 512; i++) begin
            req_valid = 1'b1;
            req_addr  = AW'(((i % NB) << BAW) | $urandom_range(0, (1 << BAW) - 1));
            if (!req_ready) drops++;
            if (seen && !rsp_valid) bubbles++;
            if (rsp_valid) seen = 1'b1;
            cycle();
        end
        chk("stream_ready_drops", drops, 0);
        chk("stream_bubbles", bubbles, 0);
        drain();

        // Backpressure: fill, then a single pop frees a single credit
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        n_acc = 0;
        for (int k = 0; k < 12; k++) begin
            req_addr = AW'($urandom_range(0, (1 << AW) - 1));
            if (req_ready) n_acc++;
            cycle();
        end
        chk("bp_accepts", n_acc, DEPTH);
        n_acc = 0;
        rsp_ready = 1'b1;
        if (req_ready) n_acc++;
        cycle();
        rsp_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            req_addr = AW'($urandom_range(0, (1 << AW) - 1));
            if (req_ready) n_acc++;
            cycle();
        end
        chk("bp_one_more", n_acc, 1);
        drain();

        // Random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            req_addr  = AW'($urandom_range(0, (1 << AW) - 1));
            cycle();
        end
        drain();

        // Reset with two reads in flight
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = AW'($urandom_range(0, (1 << AW) - 1));
        cycle();
        req_addr  = AW'($urandom_range(0, (1 << AW) - 1));
        cycle();
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_req_ready", req_ready, 0);
        vcsb = '1;
        chk("midrst_csb", csb_mem, vcsb);
        q.delete();
        ready_en = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        n_late = 0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid) n_late++;
            cycle();
        end
        chk("post_rst_no_rsp", n_late, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/merge_memory_banked.md
Name: merge_memory_banked

Overview:
- Parametrised, pipelined merger of NUM_BANKS single-port synchronous SRAM read macros into one flat, linear read address space.
- Replaces the fixed two-bank combinational merger.
- Tags each accepted read with its bank, aligns the tag with the macro read latency, and steers the correct bank's dout into a response FIFO with valid/ready backpressure.
- Sits between the waveform-generator sample fetch logic and the sky130 SRAM macros.

Parameters:
- NUM_BANKS, 4, number of macros; power of two, minimum 2.
- BANK_AW, 9, word-address width of one macro.
- DW, 32, data width.
- RD_LATENCY, 1, macro clock-to-dout latency in cycles; legal range 1..3.
- Derived, not overridable: AW = BANK_AW + $clog2(NUM_BANKS); FIFO_DEPTH = RD_LATENCY + 2.

Ports:
- clk  input  1  single clock for the block and all macros.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  read request valid.
- req_ready  output  1  request accept; registered.
- req_addr  input  AW  flat word address.
- rsp_valid  output  1  response data valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  DW  read data.
- csb_mem  output  NUM_BANKS  per-macro chip select, active-low.
- addr_mem  output  NUM_BANKS*BANK_AW  per-macro word address; bank b occupies slice [b*BANK_AW +: BANK_AW].
- dout_mem  input  NUM_BANKS*DW  per-macro read data; bank b occupies slice [b*DW +: DW].

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (ports clk, rst_n).
- Address split:
  - bank = req_addr[AW-1:BANK_AW].
  - word = req_addr[BANK_AW-1:0].
  - Every address is in range.
- Accept: a request is accepted in any cycle where req_valid && req_ready.
- Macro drive (combinational, in the accept cycle):
  - Selected bank: csb_mem[bank]=0, addr_mem slice = word.
  - All other banks, and all banks in non-accept cycles: csb_mem=1 (deselected), addr_mem=0.
  - Unused banks are never enabled.
- Tag pipeline:
  - RD_LATENCY register stages of {valid, bank}.
  - Stage 1 loads {accept, bank} at the accept edge.
- FIFO write: when the last stage is valid, the FIFO writes dout_mem[bank] at the next clock edge.
- Response FIFO:
  - Depth FIFO_DEPTH, show-ahead.
  - rsp_valid = not empty; rsp_data = head entry.
  - Pop on rsp_valid && rsp_ready.
  - rsp_data holds its value while rsp_valid && !rsp_ready.
- Latency: accept in cycle 0 -> rsp_valid in cycle RD_LATENCY+1 when the FIFO was empty.
- Ordering: responses are returned strictly in request order, including across banks.
- Credit:
  - outstanding = valid tag stages + FIFO count.
  - req_ready register next value = (outstanding_next < FIFO_DEPTH), where outstanding_next includes this cycle's accept and pop.
  - No combinational path from rsp_ready to req_ready.
  - The FIFO never overflows.
- Throughput: with rsp_ready held at 1, one request per cycle is sustained indefinitely.
- Full/backpressure: with rsp_ready=0, at most FIFO_DEPTH requests are accepted, then req_ready=0 until a pop.
- Simultaneous push and pop on a full FIFO: legal; count is unchanged.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, FIFO pointers/count=0, all tag valids=0, csb_mem all 1, addr_mem all 0.
- After reset: req_ready rises at the first clock edge after rst_n deasserts.
- Reset mid-operation: in-flight tags and FIFO contents are discarded immediately; no stale response appears after release.

Optional Feature:
- Macro: MERGE_MEMORY_RSP_ADDR_EN.
- Defined:
  - Adds output port rsp_addr (AW bits).
  - Each FIFO entry stores the full request address alongside the data.
  - rsp_addr is aligned with rsp_data; reset value 0.
- Undefined: port absent, no address storage; the tag pipeline carries only {valid, bank}.

Test Plan:
- Reset release -> req_ready=0 during reset, 1 one edge after release; csb_mem=4'b1111 throughout reset.
- Defaults: single read req_addr=0x5A3 (bank 2, word 0x1A3) -> csb_mem=4'b1011 and addr_mem bank2=0x1A3 in the accept cycle; rsp_valid 2 cycles later with bank-2 model data.
- Streaming: 512 back-to-back reads cycling banks 0..3, rsp_ready=1 -> req_ready never drops; responses in order; zero bubbles after the first response.
- Backpressure: rsp_ready=0, req_valid=1 continuously -> exactly 3 accepts (RD_LATENCY=1), then req_ready=0; one pop -> exactly one more accept.
- Reset mid-operation: assert rst_n=0 with 2 reads in flight -> rsp_valid=0 immediately; no response within 10 cycles after release.
- Parameter sweep: RD_LATENCY=3, NUM_BANKS=8; with MERGE_MEMORY_RSP_ADDR_EN defined -> rsp_addr equals the request address for every response; latency 4 cycles.
